a_input_conditioner: RTL
========================

Name: a_input_conditioner

Overview:
- Conditions a raw, asynchronous push-button or switch level into the clean single-bit stimulus `A` consumed by the `ma` decoder stage.
- Synchronises the raw input into the clock domain, debounces it, and drives the debounced level on `A`.
- Also provides a one-cycle press strobe, a long-press flag and a saturating press counter.
- Sits directly upstream of `ma`; `A` connects straight to `ma.A`.

Parameters:
- DB_CYCLES, 16, number of consecutive stable synchronised samples needed to accept a level change (must be >= 2).
- LONG_CYCLES, 64, number of cycles the debounced level must stay high before `long_press` asserts (must be > DB_CYCLES).
- CNT_W, 8, width of the press counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- btn_raw  input  1  raw asynchronous button level.
- A  output  1  debounced level, feeds `ma.A`.
- press_pulse  output  1  one-cycle strobe on each accepted 0->1 transition of `A`.
- release_pulse  output  1  one-cycle strobe on each accepted 1->0 transition of `A`.
- long_press  output  1  high while `A` has been high for at least LONG_CYCLES cycles.
- press_cnt  output  CNT_W  number of accepted presses, saturating.

Behaviour:
- Reset is synchronous and active-high; one clock (`clk`).
- All outputs reset to 0. Internal state resets to: synchroniser flops 0, debounce counter 0, hold counter 0, FSM in IDLE_LO.
- Synchroniser: two-flop chain on `btn_raw`, giving `s`. Only `s` is used downstream.
- FSM states:
  - IDLE_LO: `A`=0. If `s`=1, load debounce counter with 1 and go to CHK_HI.
  - CHK_HI: `A`=0. If `s`=0, go to IDLE_LO and clear the counter. Otherwise increment the counter. When the counter reaches DB_CYCLES, go to IDLE_HI.
  - IDLE_HI: `A`=1. If `s`=0, load the counter with 1 and go to CHK_LO.
  - CHK_LO: `A`=1. Mirror of CHK_HI. When the counter reaches DB_CYCLES, go to IDLE_LO; any `s`=1 returns to IDLE_HI.
- `A` is registered. It rises on the clock edge on which the FSM enters IDLE_HI.
  - Latency from a clean `btn_raw` rise to `A` rise is 2 (synchroniser) + DB_CYCLES cycles, i.e. 18 cycles at default.
  - Falling latency is identical.
- `press_pulse` and `release_pulse` are registered. Each is high for exactly the one cycle in which `A` first shows its new value, and is never high in two consecutive cycles.
- Glitch rejection: any `s` pulse shorter than DB_CYCLES cycles produces no change on `A` and no strobe.
- Hold counter:
  - Clears while `A`=0 and increments while `A`=1, saturating at LONG_CYCLES.
  - `long_press` is 1 when the hold counter equals LONG_CYCLES.
  - `long_press` stays high through CHK_LO, since `A` is still 1, and drops on the cycle `A` drops.
- `press_cnt` increments by 1 on each `press_pulse` and saturates at 2^CNT_W - 1 (no wrap). It is cleared only by `rst`.
- Reset mid-operation, from any state or count: the next edge with `rst`=1 forces the reset values, including `A`=0, even if `btn_raw` is held high.
  - After `rst` deasserts with `btn_raw` high, a full 2 + DB_CYCLES cycles pass before `A`=1, and this counts as one press.
- Simultaneous events: a debounce completion and `rst` on the same edge resolve as `rst` wins.

Test Plan:
- Reset with `btn_raw`=0 -> all outputs 0; then hold `btn_raw`=1 for 40 cycles -> `A` rises at cycle 18 after the raw edge, `press_pulse`=1 for exactly that cycle, `press_cnt`=1, `long_press`=0.
- Bounce: toggle `btn_raw` 1/0 every 3 cycles for 30 cycles, then hold 0 -> `A` stays 0, no strobes, `press_cnt` unchanged.
- Long press: hold `btn_raw`=1 for 100 cycles -> `long_press` asserts 64 cycles after `A` rises. On release, `A` falls 18 cycles after the raw edge, `release_pulse` lasts 1 cycle, and `long_press` drops the same cycle as `A`.
- Mirror of `ma` stimulus: raw pulses of 30 cycles high / 30 cycles low, repeated 4 times -> 4 clean `A` pulses each 30 cycles wide, `press_cnt`=4.
- Saturation with CNT_W=2: 5 clean presses -> `press_cnt` reads 1, 2, 3, 3, 3.
- Reset mid-press: assert `rst` for 1 cycle while `A`=1 and `btn_raw`=1 -> `A`, `long_press` and `press_cnt` become 0 on that edge; `A` returns to 1 after 18 cycles, with `press_cnt`=1.

Source files
------------

// File: rtl/a_input_conditioner_if.sv
// Button conditioner bundle: raw level in, debounced level and press events out.
interface a_input_conditioner_if #(
    parameter int CNT_W = 8
);
    logic             btn_raw;
    logic             A;
    logic             press_pulse;
    logic             release_pulse;
    logic             long_press;
    logic [CNT_W-1:0] press_cnt;

    // master is the conditioner itself; slave is the stimulus source / consumer side
    modport master (
        input  btn_raw,
        output A, press_pulse, release_pulse, long_press, press_cnt
    );
    modport slave (
        output btn_raw,
        input  A, press_pulse, release_pulse, long_press, press_cnt
    );
endinterface

// File: rtl/a_input_conditioner.sv
// Purpose: synchronise and debounce a raw button into A, with press/release strobes, long-press flag, press counter.
// Latency: 2 + DB_CYCLES cycles from a clean raw edge to A (strobes coincide with the A edge).
// Backpressure: none; free-running level path, every accepted edge is reported.
module a_input_conditioner #(
    parameter int DB_CYCLES   = 16,
    parameter int LONG_CYCLES = 64,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    a_input_conditioner_if.master io
);
    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    typedef enum logic [1:0] {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} state_t;

    state_t            state;
    logic              sync1;
    logic              s;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              a_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              rise;
    logic              fall;
    logic              a_next;
    logic [HOLD_W-1:0] hold_next;

    // The DB_CYCLES-th consecutive stable sample is the one that flips A.
    always_comb begin
        rise      = (state == CHK_HI) &&  s && (db_cnt == DB_LAST);
        fall      = (state == CHK_LO) && !s && (db_cnt == DB_LAST);
        a_next    = rise ? 1'b1 : (fall ? 1'b0 : a_q);
        hold_next = '0;
        if (a_q) begin
            hold_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE_LO;
            sync1     <= 1'b0;
            s         <= 1'b0;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            a_q       <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1 <= io.btn_raw;
            s     <= sync1;

            case (state)
                IDLE_LO: begin
                    if (s) begin
                        db_cnt <= DB_ONE;
                        state  <= CHK_HI;
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        db_cnt <= '0;
                        state  <= IDLE_LO;
                    end else if (rise) begin
                        db_cnt <= '0;
                        state  <= IDLE_HI;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                IDLE_HI: begin
                    if (!s) begin
                        db_cnt <= DB_ONE;
                        state  <= CHK_LO;
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        db_cnt <= '0;
                        state  <= IDLE_HI;
                    end else if (fall) begin
                        db_cnt <= '0;
                        state  <= IDLE_LO;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    db_cnt <= '0;
                    state  <= IDLE_LO;
                end
            endcase

            a_q       <= a_next;
            press_q   <= rise;
            release_q <= fall;
            hold_cnt  <= hold_next;
            // Gated by a_next so the flag drops on the same edge as A.
            long_q    <= a_next && (hold_next == HOLD_MAX);
            if (rise && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign io.A             = a_q;
    assign io.press_pulse   = press_q;
    assign io.release_pulse = release_q;
    assign io.long_press    = long_q;
    assign io.press_cnt     = cnt_q;
endmodule
